// File: rtl/mac_align_rx_pkg.sv
// Shared types and helpers for the mac_align_rx receive alignment stage.
package mac_rx_pkg;

  localparam int unsigned MAC_KEEP_W  = 8;
  localparam int unsigned MAC_KEEP_W1 = MAC_KEEP_W + 1;
  localparam int unsigned MAC_BCNT_W  = 4;

  // Bit positions inside start_v_i
  localparam int unsigned START_OCT0 = 0;
  localparam int unsigned START_OCT4 = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ALIGN = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Byte count (0..8) to low-contiguous byte enables
  function automatic logic [MAC_KEEP_W-1:0] cnt_to_keep(input logic [MAC_BCNT_W-1:0] cnt);
    logic [MAC_KEEP_W1-1:0] ones;
    ones = MAC_KEEP_W1'(1) << cnt;
    return MAC_KEEP_W'(ones - MAC_KEEP_W1'(1));
  endfunction

endpackage

// File: rtl/mac_align_rx_if.sv
// PCS-decoder input bus and aligned frame output bus of mac_align_rx.
interface mac_align_rx_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 32
);
  logic              valid_i;
  logic              ctrl_v_i;
  logic              idle_v_i;
  logic [1:0]        start_v_i;
  logic              term_v_i;
  logic              err_v_i;
  logic [DATA_W-1:0] data_i;
  logic [KEEP_W-1:0] keep_i;

  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [KEEP_W-1:0] keep_o;
  logic              last_o;
  logic              err_o;
  logic [CNT_W-1:0]  frame_cnt_o;
  logic [CNT_W-1:0]  err_cnt_o;

  modport slave (
    input  valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, data_i, keep_i,
    output valid_o, data_o, keep_o, last_o, err_o, frame_cnt_o, err_cnt_o
  );

  modport master (
    output valid_i, ctrl_v_i, idle_v_i, start_v_i, term_v_i, err_v_i, data_i, keep_i,
    input  valid_o, data_o, keep_o, last_o, err_o, frame_cnt_o, err_cnt_o
  );
endinterface

// File: rtl/mac_align_rx_keep_cnt_rx.sv
// Combinational popcount of a keep vector into a byte count.
module keep_cnt_rx
  import mac_rx_pkg::*;
#(
  parameter int unsigned KEEP_W = MAC_KEEP_W
) (
  input  logic [KEEP_W-1:0]     keep_i,
  output logic [MAC_BCNT_W-1:0] byte_cnt_c_o
);

  always_comb begin
    byte_cnt_c_o = '0;
    for (int unsigned i = 0; i < KEEP_W; i++) begin
      byte_cnt_c_o = byte_cnt_c_o + MAC_BCNT_W'(keep_i[i]);
    end
  end

endmodule

// File: rtl/mac_align_rx.sv
// Realigns PCS RX blocks into a byte-0-aligned frame stream and polices framing.
// Statistics counters exist only when MAC_ALIGN_RX_STATS_EN is defined.
module mac_align_rx
  import mac_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8,
  parameter int unsigned CNT_W  = 32
) (
  input  logic          clk,
  input  logic          nreset,
  mac_align_rx_if.slave bus
);

  localparam int unsigned HALF_W = DATA_W / 2;
  localparam int unsigned HALF_B = KEEP_W / 2;

  state_e                  state_q, state_d;
  logic [HALF_W-1:0]       hold_q, hold_d;
  logic [MAC_BCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic                    valid_q, valid_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [KEEP_W-1:0]       keep_q, keep_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;
  logic                    frame_inc_c, err_inc_c;
  logic                    blk_err_c, blk_stray_c;
  logic [MAC_BCNT_W-1:0]   term_cnt_c;
  logic                    unused_idle;

  keep_cnt_rx #(.KEEP_W(KEEP_W)) u_keep_cnt (
    .keep_i       (bus.keep_i),
    .byte_cnt_c_o (term_cnt_c)
  );

  // Idle and ordered-set blocks are both "control, not term" for framing purposes
  assign unused_idle = bus.idle_v_i;

  assign blk_err_c   = bus.err_v_i || (|bus.start_v_i) || (bus.ctrl_v_i && !bus.term_v_i);
  assign blk_stray_c = !bus.err_v_i && (bus.start_v_i == 2'b00) &&
                       (!bus.ctrl_v_i || bus.term_v_i);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    flush_cnt_d = flush_cnt_q;
    valid_d     = 1'b0;
    data_d      = '0;
    keep_d      = '0;
    last_d      = 1'b0;
    err_d       = 1'b0;
    frame_inc_c = 1'b0;
    err_inc_c   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          if (bus.start_v_i[START_OCT0]) begin
            state_d = ST_ALIGN;
            valid_d = 1'b1;
            data_d  = bus.data_i;
            keep_d  = '1;
          end else if (bus.start_v_i[START_OCT4]) begin
            state_d = ST_SHIFT;
            hold_d  = bus.data_i[DATA_W-1 -: HALF_W];
          end else if (blk_stray_c) begin
            err_inc_c = 1'b1;
          end
        end
      end

      ST_ALIGN: begin
        if (bus.valid_i) begin
          valid_d = 1'b1;
          if (blk_err_c) begin
            last_d    = 1'b1;
            err_d     = 1'b1;
            err_inc_c = 1'b1;
            state_d   = ST_IDLE;
          end else if (bus.ctrl_v_i) begin
            data_d      = bus.data_i;
            keep_d      = cnt_to_keep(term_cnt_c);
            last_d      = 1'b1;
            frame_inc_c = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            data_d = bus.data_i;
            keep_d = '1;
          end
        end
      end

      ST_SHIFT: begin
        if (bus.valid_i) begin
          valid_d = 1'b1;
          if (blk_err_c) begin
            data_d    = {{HALF_W{1'b0}}, hold_q};
            keep_d    = cnt_to_keep(MAC_BCNT_W'(HALF_B));
            last_d    = 1'b1;
            err_d     = 1'b1;
            err_inc_c = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            data_d = {bus.data_i[HALF_W-1:0], hold_q};
            if (!bus.ctrl_v_i) begin
              keep_d = '1;
              hold_d = bus.data_i[DATA_W-1 -: HALF_W];
            end else if (term_cnt_c <= MAC_BCNT_W'(HALF_B)) begin
              keep_d      = cnt_to_keep(MAC_BCNT_W'(HALF_B) + term_cnt_c);
              last_d      = 1'b1;
              frame_inc_c = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              // Tail spills past this beat: park the upper half for one more beat
              keep_d      = '1;
              hold_d      = bus.data_i[DATA_W-1 -: HALF_W];
              flush_cnt_d = term_cnt_c - MAC_BCNT_W'(HALF_B);
              state_d     = ST_FLUSH;
            end
          end
        end
      end

      ST_FLUSH: begin
        // The flush beat needs no input, so it goes out even on a stall
        valid_d     = 1'b1;
        data_d      = {{HALF_W{1'b0}}, hold_q};
        keep_d      = cnt_to_keep(flush_cnt_q);
        last_d      = 1'b1;
        frame_inc_c = 1'b1;
        state_d     = ST_IDLE;
        if (bus.valid_i) begin
          if (bus.start_v_i[START_OCT0]) begin
            err_inc_c = 1'b1;
          end else if (bus.start_v_i[START_OCT4]) begin
            hold_d  = bus.data_i[DATA_W-1 -: HALF_W];
            state_d = ST_SHIFT;
          end else if (blk_stray_c) begin
            err_inc_c = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      flush_cnt_q <= '0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      flush_cnt_q <= flush_cnt_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      keep_q      <= keep_d;
      last_q      <= last_d;
      err_q       <= err_d;
    end
  end

  assign bus.valid_o = valid_q;
  assign bus.data_o  = data_q;
  assign bus.keep_o  = keep_q;
  assign bus.last_o  = last_q;
  assign bus.err_o   = err_q;

`ifdef MAC_ALIGN_RX_STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

  // Saturating statistics, updated on the same edge as the closing beat
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      if (frame_inc_c && (frame_cnt_q != '1)) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      if (err_inc_c && (err_cnt_q != '1))     err_cnt_q   <= err_cnt_q + CNT_W'(1);
    end
  end

  assign bus.frame_cnt_o = frame_cnt_q;
  assign bus.err_cnt_o   = err_cnt_q;
`else
  logic unused_stats;
  assign unused_stats    = frame_inc_c | err_inc_c;
  assign bus.frame_cnt_o = CNT_W'(0);
  assign bus.err_cnt_o   = CNT_W'(0);
`endif

endmodule
